// File: rtl/axi_enhanced_tx_sched_pkg.sv
// Shared definitions for the enhanced AXI TX weighted round-robin scheduler:
// channel encodings, FSM states, counter widths and channel rotation helper.
package axi_enhanced_tx_sched_pkg;

  localparam logic [1:0] CH_RR  = 2'b00;
  localparam logic [1:0] CH_RW  = 2'b01;
  localparam logic [1:0] CH_CC  = 2'b10;
  localparam logic [1:0] CH_CFG = 2'b11;

  localparam int CNT_W = 4;
  localparam int TMR_W = 12;

  typedef enum logic [1:0] {
    LINKDN = 2'd0,
    IDLE   = 2'd1,
    BUSY   = 2'd2
  } sched_state_e;

  // WRR rotation order RR -> RW -> CC -> RR; CFG never sits on the pointer.
  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    case (ch)
      CH_RR:   return CH_RW;
      CH_RW:   return CH_CC;
      default: return CH_RR;
    endcase
  endfunction

endpackage

// File: rtl/axi_enhanced_tx_wrr_sched_if.sv
// Source-valid, muxed-stream handshake and mux-control bundle between the TX
// sources and the WRR scheduler. master = source/stream side, slave = scheduler.
interface axi_enhanced_tx_wrr_sched_if;
  logic       s_axis_rr_tvalid;
  logic       s_axis_rw_tvalid;
  logic       s_axis_cc_tvalid;
  logic       s_axis_cfg_tvalid;
  logic       cfg_req;
  logic       cc_in_packet;
  logic       s_axis_tx_tvalid;
  logic       s_axis_tx_tready;
  logic       s_axis_tx_tlast;
  logic       trn_lnk_up;
  logic [1:0] channel_sel;
  logic       grant_valid;
  logic       rr_thrtl;
  logic       rw_thrtl;
  logic       cc_thrtl;
  logic       starve_event;

  modport master (
    output s_axis_rr_tvalid, s_axis_rw_tvalid, s_axis_cc_tvalid, s_axis_cfg_tvalid,
    output cfg_req, cc_in_packet,
    output s_axis_tx_tvalid, s_axis_tx_tready, s_axis_tx_tlast, trn_lnk_up,
    input  channel_sel, grant_valid, rr_thrtl, rw_thrtl, cc_thrtl, starve_event
  );

  modport slave (
    input  s_axis_rr_tvalid, s_axis_rw_tvalid, s_axis_cc_tvalid, s_axis_cfg_tvalid,
    input  cfg_req, cc_in_packet,
    input  s_axis_tx_tvalid, s_axis_tx_tready, s_axis_tx_tlast, trn_lnk_up,
    output channel_sel, grant_valid, rr_thrtl, rw_thrtl, cc_thrtl, starve_event
  );
endinterface

// File: rtl/axi_enhanced_tx_starve_timer.sv
// Single-channel wait timer: counts cycles a source waits with data while not
// granted and flags it starved once the wait reaches STARVE_LIMIT.
module axi_enhanced_tx_starve_timer
  import axi_enhanced_tx_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic starved
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(STARVE_LIMIT);

  logic [TMR_W-1:0] tmr_r;

  assign starved = (tmr_r >= LIMIT);

  // Wait counter; stops at the limit so it cannot wrap while the source waits.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tmr_r <= '0;
    end else if (run && !starved) begin
      tmr_r <= tmr_r + TMR_W'(1);
    end
  end

endmodule

// File: rtl/axi_enhanced_tx_wrr_sched.sv
// Weighted round-robin packet scheduler for the enhanced AXI-to-TRN TX path.
// Grants one of RR/RW/CC/CFG per packet, drives the mux select and per-source
// throttles from registers. Optional starvation guard: define
// AXI_TX_SCHED_STARVE_GUARD_EN to add per-channel wait timers.
module axi_enhanced_tx_wrr_sched
  import axi_enhanced_tx_sched_pkg::*;
#(
  parameter int W_RR         = 4,
  parameter int W_RW         = 4,
  parameter int W_CC         = 8,
  parameter int STARVE_LIMIT = 256,
  parameter int TCQ          = 1
) (
  input logic                         com_iclk,
  input logic                         com_sysrst,
  axi_enhanced_tx_wrr_sched_if.slave  tx
);

  // TCQ is carried for drop-in compatibility; outputs are plain registers.
  if (W_RR < 1 || W_RR > 15 || W_RW < 1 || W_RW > 15 || W_CC < 1 || W_CC > 15 ||
      STARVE_LIMIT < 16 || STARVE_LIMIT > 4095 || TCQ < 0) begin : g_param_check
    $error("axi_enhanced_tx_wrr_sched: parameter out of range");
  end

  localparam logic [CNT_W-1:0] WT_RR = CNT_W'(W_RR);
  localparam logic [CNT_W-1:0] WT_RW = CNT_W'(W_RW);
  localparam logic [CNT_W-1:0] WT_CC = CNT_W'(W_CC);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] weight_of(input logic [1:0] ch);
    case (ch)
      CH_RR:   return WT_RR;
      CH_RW:   return WT_RW;
      default: return WT_CC;
    endcase
  endfunction

  // Throttle pattern {cc, rw, rr}: only the granted data source is released.
  function automatic logic [2:0] thr_of(input logic [1:0] ch);
    case (ch)
      CH_RR:   return 3'b110;
      CH_RW:   return 3'b101;
      CH_CC:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  sched_state_e     state_r, state_nxt;
  logic [1:0]       sel_r, sel_nxt;
  logic             gv_r, gv_nxt;
  logic [2:0]       thr_r, thr_nxt;
  logic             se_r, se_nxt;
  logic [1:0]       ptr_r, ptr_nxt;
  logic [CNT_W-1:0] cnt_r [4];
  logic [CNT_W-1:0] cnt_nxt [4];

  logic [3:0] src_vld;
  logic [2:0] starved;
  logic [2:0] starved_vld;
  logic [1:0] n1, n2;
  logic [1:0] win_ch;
  logic       win_vld, win_starve, ptr_adv, eop;

  assign src_vld = {tx.s_axis_cfg_tvalid, tx.s_axis_cc_tvalid,
                    tx.s_axis_rw_tvalid,  tx.s_axis_rr_tvalid};
  assign eop     = tx.s_axis_tx_tvalid & tx.s_axis_tx_tready & tx.s_axis_tx_tlast;
  assign starved_vld = starved & src_vld[2:0];

`ifdef AXI_TX_SCHED_STARVE_GUARD_EN
  logic tmr_clr;
  assign tmr_clr = (state_r == LINKDN) || !tx.trn_lnk_up;

  for (genvar i = 0; i < 3; i++) begin : g_tmr
    axi_enhanced_tx_starve_timer #(
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_tmr (
      .clk     (com_iclk),
      .rst     (com_sysrst),
      .clr     (tmr_clr || (gv_r && (sel_r == 2'(i)))),
      .run     (src_vld[i]),
      .starved (starved[i])
    );
  end
`else
  assign starved = 3'b000;
`endif

  // Arbitration winner for the IDLE decision: CFG, CC continuation, starved,
  // pointer within weight, then the next valid channel after the pointer.
  always_comb begin
    win_vld    = 1'b1;
    win_ch     = ptr_r;
    win_starve = 1'b0;
    n1         = next_ch(ptr_r);
    n2         = next_ch(n1);
    ptr_adv    = !src_vld[ptr_r] || (cnt_r[ptr_r] >= weight_of(ptr_r));
    if (src_vld[3] && tx.cfg_req) begin
      win_ch = CH_CFG;
    end else if (src_vld[2] && tx.cc_in_packet) begin
      win_ch = CH_CC;
    end else if (|starved_vld) begin
      win_starve = 1'b1;
      if (starved_vld[0])      win_ch = CH_RR;
      else if (starved_vld[1]) win_ch = CH_RW;
      else                     win_ch = CH_CC;
    end else if (!ptr_adv) begin
      win_ch = ptr_r;
    end else if (src_vld[n1]) begin
      win_ch = n1;
    end else if (src_vld[n2]) begin
      win_ch = n2;
    end else if (src_vld[ptr_r]) begin
      win_ch = ptr_r;
    end else begin
      win_vld = 1'b0;
    end
  end

  // FSM next state, WRR pointer/count bookkeeping and registered-output targets.
  always_comb begin
    state_nxt = state_r;
    sel_nxt   = sel_r;
    gv_nxt    = gv_r;
    thr_nxt   = thr_r;
    se_nxt    = 1'b0;
    ptr_nxt   = ptr_r;
    cnt_nxt   = cnt_r;
    if (!tx.trn_lnk_up) begin
      state_nxt = LINKDN;
      gv_nxt    = 1'b0;
      thr_nxt   = 3'b111;
      ptr_nxt   = CH_RR;
      for (int i = 0; i < 4; i++) cnt_nxt[i] = '0;
    end else begin
      case (state_r)
        LINKDN: begin
          state_nxt = IDLE;
          gv_nxt    = 1'b0;
          thr_nxt   = 3'b111;
        end
        IDLE: begin
          gv_nxt  = 1'b0;
          thr_nxt = 3'b111;
          if (win_vld) begin
            state_nxt = BUSY;
            sel_nxt   = win_ch;
            gv_nxt    = 1'b1;
            thr_nxt   = thr_of(win_ch);
            se_nxt    = win_starve;
          end
          // A CFG grant leaves the WRR round untouched.
          if (ptr_adv && !(win_vld && (win_ch == CH_CFG))) begin
            cnt_nxt[ptr_r] = '0;
            ptr_nxt        = next_ch(ptr_r);
          end
        end
        BUSY: begin
          if (eop) begin
            state_nxt = IDLE;
            gv_nxt    = 1'b0;
            thr_nxt   = 3'b111;
            if (sel_r != CH_CFG) cnt_nxt[sel_r] = sat_inc(cnt_r[sel_r]);
          end
        end
        default: state_nxt = LINKDN;
      endcase
    end
  end

  // Registered state and outputs.
  always_ff @(posedge com_iclk) begin
    if (com_sysrst) begin
      state_r <= IDLE;
      sel_r   <= CH_RR;
      gv_r    <= 1'b0;
      thr_r   <= 3'b111;
      se_r    <= 1'b0;
      ptr_r   <= CH_RR;
      for (int i = 0; i < 4; i++) cnt_r[i] <= '0;
    end else begin
      state_r <= state_nxt;
      sel_r   <= sel_nxt;
      gv_r    <= gv_nxt;
      thr_r   <= thr_nxt;
      se_r    <= se_nxt;
      ptr_r   <= ptr_nxt;
      for (int i = 0; i < 4; i++) cnt_r[i] <= cnt_nxt[i];
    end
  end

  assign tx.channel_sel  = sel_r;
  assign tx.grant_valid  = gv_r;
  assign tx.rr_thrtl     = thr_r[0];
  assign tx.rw_thrtl     = thr_r[1];
  assign tx.cc_thrtl     = thr_r[2];
  assign tx.starve_event = se_r;

endmodule

// File: tb/tb_axi_enhanced_tx_wrr_sched.sv
// Directed bench for the WRR TX scheduler: single-decision arbitration table
// plus hand-written multi-cycle sequences (WRR ratio, CFG preemption, CC
// continuation, link drop, reset mid-packet, starvation when the guard is built).
module tb_axi_enhanced_tx_wrr_sched;
  import axi_enhanced_tx_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  axi_enhanced_tx_wrr_sched_if bus();

  axi_enhanced_tx_wrr_sched #(
    .W_RR(2), .W_RW(1), .W_CC(1), .STARVE_LIMIT(256), .TCQ(1)
  ) dut (
    .com_iclk   (clk),
    .com_sysrst (rst),
    .tx         (bus)
  );

`ifdef AXI_TX_SCHED_STARVE_GUARD_EN
  axi_enhanced_tx_wrr_sched_if sbus();

  axi_enhanced_tx_wrr_sched #(
    .W_RR(15), .W_RW(4), .W_CC(8), .STARVE_LIMIT(16), .TCQ(1)
  ) dut_sg (
    .com_iclk   (clk),
    .com_sysrst (rst),
    .tx         (sbus)
  );

  assign sbus.s_axis_tx_tvalid = sbus.grant_valid;
`endif

  // {cc_in_packet, cfg_req, cfg, cc, rw, rr}
  typedef struct {
    logic [5:0] src;
    logic [1:0] sel;
    logic       gv;
    logic [2:0] thr;   // {cc, rw, rr}
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input logic [5:0] s);
    bus.s_axis_rr_tvalid  = s[0];
    bus.s_axis_rw_tvalid  = s[1];
    bus.s_axis_cc_tvalid  = s[2];
    bus.s_axis_cfg_tvalid = s[3];
    bus.cfg_req           = s[4];
    bus.cc_in_packet      = s[5];
  endtask

  task automatic set_tx(input logic v, input logic r, input logic l);
    bus.s_axis_tx_tvalid = v;
    bus.s_axis_tx_tready = r;
    bus.s_axis_tx_tlast  = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_src(6'b0);
    set_tx(1'b0, 1'b0, 1'b0);
    bus.trn_lnk_up = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // {0, sel[1:0], gv, cc_thrtl, rw_thrtl, rr_thrtl, starve_event}
  function automatic logic [7:0] outs();
    return {1'b0, bus.channel_sel, bus.grant_valid,
            bus.cc_thrtl, bus.rw_thrtl, bus.rr_thrtl, bus.starve_event};
  endfunction

  function automatic logic [7:0] exp_o(input logic [1:0] sel, input logic gv,
                                       input logic [2:0] thr);
    return {1'b0, sel, gv, thr, 1'b0};
  endfunction

  // Watchdog: the sequences are fixed length, this only guards against a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [13];
    logic [1:0] pat  [4];
    int         cc_at;
    int         pulses;

    vecs[0]  = '{6'b000000, CH_RR,  1'b0, 3'b111};
    vecs[1]  = '{6'b000001, CH_RR,  1'b1, 3'b110};
    vecs[2]  = '{6'b000010, CH_RW,  1'b1, 3'b101};
    vecs[3]  = '{6'b000100, CH_CC,  1'b1, 3'b011};
    vecs[4]  = '{6'b000111, CH_RR,  1'b1, 3'b110};
    vecs[5]  = '{6'b000110, CH_RW,  1'b1, 3'b101};
    vecs[6]  = '{6'b100111, CH_CC,  1'b1, 3'b011};
    vecs[7]  = '{6'b011111, CH_CFG, 1'b1, 3'b111};
    vecs[8]  = '{6'b001001, CH_RR,  1'b1, 3'b110};
    vecs[9]  = '{6'b010010, CH_RW,  1'b1, 3'b101};
    vecs[10] = '{6'b100011, CH_RR,  1'b1, 3'b110};
    vecs[11] = '{6'b111100, CH_CFG, 1'b1, 3'b111};
    vecs[12] = '{6'b001000, CH_RR,  1'b0, 3'b111};

    pat[0] = CH_RR; pat[1] = CH_RR; pat[2] = CH_RW; pat[3] = CH_CC;

    bus.trn_lnk_up = 1'b1;
    set_src(6'b000111);
    set_tx(1'b0, 1'b0, 1'b0);
`ifdef AXI_TX_SCHED_STARVE_GUARD_EN
    sbus.s_axis_rr_tvalid  = 1'b0;
    sbus.s_axis_rw_tvalid  = 1'b0;
    sbus.s_axis_cc_tvalid  = 1'b0;
    sbus.s_axis_cfg_tvalid = 1'b0;
    sbus.cfg_req           = 1'b0;
    sbus.cc_in_packet      = 1'b0;
    sbus.s_axis_tx_tready  = 1'b1;
    sbus.s_axis_tx_tlast   = 1'b1;
    sbus.trn_lnk_up        = 1'b1;
`endif

    // Reset values while sources are requesting.
    step();
    check("reset_state", outs(), exp_o(CH_RR, 1'b0, 3'b111));

    // Arbitration table: one decision from a clean IDLE state each.
    for (int v = 0; v < 13; v++) begin
      do_reset();
      set_src(vecs[v].src);
      step();
      check($sformatf("arb_vec%0d", v), outs(), exp_o(vecs[v].sel, vecs[v].gv, vecs[v].thr));
    end

    // WRR ratio 2:1:1 with 1-beat packets and one bubble between grants.
    do_reset();
    set_src(6'b000111);
    set_tx(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("wrr_cyc%0d", i), {bus.channel_sel, bus.grant_valid},
            {pat[(i / 2) % 4], 1'b1 ^ 1'(i % 2)});
    end

    // CFG request mid RR packet: RR finishes, CFG two cycles after tlast.
    do_reset();
    set_src(6'b000011);
    set_tx(1'b1, 1'b1, 1'b0);
    step();
    check("cfg_rr_grant", outs(), exp_o(CH_RR, 1'b1, 3'b110));
    step();
    check("cfg_beat1", {bus.channel_sel, bus.grant_valid}, {CH_RR, 1'b1});
    set_src(6'b011011);
    step();
    check("cfg_beat2", {bus.channel_sel, bus.grant_valid}, {CH_RR, 1'b1});
    step();
    check("cfg_beat3", {bus.channel_sel, bus.grant_valid}, {CH_RR, 1'b1});
    set_tx(1'b1, 1'b1, 1'b1);
    step();
    check("cfg_bubble", bus.grant_valid, 1'b0);
    step();
    check("cfg_grant", outs(), exp_o(CH_CFG, 1'b1, 3'b111));
    set_src(6'b000011);
    step();
    check("cfg_eop", bus.grant_valid, 1'b0);
    step();
    check("cfg_ptr_kept", outs(), exp_o(CH_RR, 1'b1, 3'b110));

    // CC continuation wins over RW sitting at the pointer.
    do_reset();
    set_tx(1'b1, 1'b1, 1'b1);
    step();
    check("cc_idle", bus.grant_valid, 1'b0);
    set_src(6'b100110);
    step();
    check("cc_first", outs(), exp_o(CH_CC, 1'b1, 3'b011));
    set_src(6'b000110);
    step();
    check("cc_eop", bus.grant_valid, 1'b0);
    step();
    check("cc_then_rw", outs(), exp_o(CH_RW, 1'b1, 3'b101));

    // Link drop mid RW packet (coincident with tlast), then relink.
    do_reset();
    set_src(6'b000010);
    set_tx(1'b1, 1'b1, 1'b0);
    step();
    check("lnk_rw_grant", outs(), exp_o(CH_RW, 1'b1, 3'b101));
    step();
    bus.trn_lnk_up = 1'b0;
    set_tx(1'b1, 1'b1, 1'b1);
    step();
    check("lnk_down", {bus.grant_valid, bus.cc_thrtl, bus.rw_thrtl, bus.rr_thrtl}, 4'b0111);
    step();
    check("lnk_down_hold", {bus.grant_valid, bus.cc_thrtl, bus.rw_thrtl, bus.rr_thrtl}, 4'b0111);
    bus.trn_lnk_up = 1'b1;
    set_src(6'b000011);
    set_tx(1'b1, 1'b1, 1'b0);
    step();
    check("lnk_relink_idle", bus.grant_valid, 1'b0);
    step();
    check("lnk_ptr_rr", outs(), exp_o(CH_RR, 1'b1, 3'b110));

    // Reset asserted mid RW packet.
    do_reset();
    set_src(6'b000010);
    set_tx(1'b1, 1'b1, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_mid_pkt", outs(), exp_o(CH_RR, 1'b0, 3'b111));
    step();
    check("rst_held", bus.grant_valid, 1'b0);
    rst = 1'b0;
    step();
    check("rst_regrant", outs(), exp_o(CH_RW, 1'b1, 3'b101));

`ifdef AXI_TX_SCHED_STARVE_GUARD_EN
    // RR streams at weight 15; the guard must force CC in within 18 cycles.
    do_reset();
    sbus.s_axis_rr_tvalid = 1'b1;
    sbus.s_axis_cc_tvalid = 1'b1;
    cc_at  = -1;
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (sbus.starve_event) pulses++;
      if (cc_at < 0 && sbus.grant_valid && sbus.channel_sel == CH_CC) cc_at = i;
    end
    check("starve_cc_in_time", 32'(cc_at >= 1 && cc_at <= 18), 32'd1);
    check("starve_pulse_once", 32'(pulses), 32'd1);
`else
    cc_at  = 0;
    pulses = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
